layer_3_maxpool: RTL and testbench

Streaming 2x2, stride-2 max-pooling stage that feeds the layer-4 feature-map convolution blocks. It takes a raster-ordered 208x208 feature map with 32 channels in parallel and emits a 104x104 map in the same packed format. Each input beat carries one pixel as 32 IEEE-754 fp32 values on a 1024-bit bus. Output format and handshake match what every layer-4 featuremap block consumes on `data_in`/`valid_in`.

---
 rtl/layer_3_maxpool_if.sv | 30 +++
 rtl/layer_3_maxpool.sv | 107 ++++++++++
 tb/tb_layer_3_maxpool.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/layer_3_maxpool_if.sv
// Pixel stream bundle for the 2x2 max-pool stage: packed multi-channel input
// beats in, pooled pixels out with a frame-end marker.
interface layer_3_maxpool_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 32
);
  localparam int BUS_W = DATA_WIDTH * CHANNELS;

  logic [BUS_W-1:0] data_in;
  logic             valid_in;
  logic [BUS_W-1:0] data_out;
  logic             valid_out;
  logic             last_out;

  modport slave (
    input  data_in,
    input  valid_in,
    output data_out,
    output valid_out,
    output last_out
  );

  modport master (
    output data_in,
    output valid_in,
    input  data_out,
    input  valid_out,
    input  last_out
  );
endinterface

// File: rtl/layer_3_maxpool.sv
// Streaming 2x2 stride-2 max-pool over raster-ordered multi-channel fp32 pixels.
// Horizontal pairs are reduced on the fly; even-row results wait in a line buffer.
module layer_3_maxpool #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 32,
  parameter int IN_SIZE    = 208
) (
  input  logic              Clk,
  input  logic              Rst,
  layer_3_maxpool_if.slave  bus
);
  localparam int BUS_W = DATA_WIDTH * CHANNELS;
  localparam int CW    = $clog2(IN_SIZE);
  localparam int HALF  = IN_SIZE / 2;
  localparam int IW    = (CW > 1) ? CW - 1 : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(IN_SIZE - 1);

  // Bit-pattern fp max: sign decides first, then magnitude; ties keep a.
  function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic sa, sb;
    logic [DATA_WIDTH-2:0] ma, mb;
    sa = a[DATA_WIDTH-1];
    sb = b[DATA_WIDTH-1];
    ma = a[DATA_WIDTH-2:0];
    mb = b[DATA_WIDTH-2:0];
    if (sa != sb) return sa ? b : a;
    else if (!sa) return (mb > ma) ? b : a;
    else return (mb < ma) ? b : a;
  endfunction

  function automatic logic [BUS_W-1:0] vec_max(input logic [BUS_W-1:0] a,
                                               input logic [BUS_W-1:0] b);
    logic [BUS_W-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++)
      r[k*DATA_WIDTH +: DATA_WIDTH] = fp_max(a[k*DATA_WIDTH +: DATA_WIDTH],
                                             b[k*DATA_WIDTH +: DATA_WIDTH]);
    return r;
  endfunction

  logic [CW-1:0]    col_q, col_d, row_q, row_d;
  logic [BUS_W-1:0] pend_q, pend_d, data_q, data_d;
  logic             valid_q, valid_d, last_q, last_d;
  logic [BUS_W-1:0] h_max, v_max;
  logic [IW-1:0]    lb_idx;
  logic             lb_we;
  logic [BUS_W-1:0] line_buf [HALF];

  assign lb_idx = IW'(col_q >> 1);
  assign h_max  = vec_max(pend_q, bus.data_in);
  assign v_max  = vec_max(line_buf[lb_idx], h_max);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    pend_d  = pend_q;
    data_d  = data_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    lb_we   = 1'b0;
    if (bus.valid_in) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        pend_d = bus.data_in;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        valid_d = 1'b1;
        data_d  = v_max;
        last_d  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col_q   <= '0;
      row_q   <= '0;
      pend_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // Always written on an even row before being read, so no reset is needed.
  always_ff @(posedge Clk) begin
    if (lb_we) line_buf[lb_idx] <= h_max;
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.last_out  = last_q;
endmodule

// File: tb/tb_layer_3_maxpool.sv
// Bench for layer_3_maxpool: table-driven 4x4 frames plus a full-size random
// frame checked against an order-key reference model.
module tb_layer_3_maxpool;
  localparam int DW = 32, SN = 4, SCH = 2, BN = 208, BCH = 32;
  localparam int BPIX = BN * BN, BOUT = (BN / 2) * (BN / 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_3_maxpool_if #(.DATA_WIDTH(DW), .CHANNELS(SCH)) sif ();
  layer_3_maxpool_if #(.DATA_WIDTH(DW), .CHANNELS(BCH)) bif ();

  layer_3_maxpool #(.DATA_WIDTH(DW), .CHANNELS(SCH), .IN_SIZE(SN)) u_small (
    .Clk(clk), .Rst(rst_n), .bus(sif.slave));
  layer_3_maxpool #(.DATA_WIDTH(DW), .CHANNELS(BCH), .IN_SIZE(BN)) u_big (
    .Clk(clk), .Rst(rst_n), .bus(bif.slave));

  typedef struct {
    string            name;
    logic [15:0][31:0] ch0;
    logic [15:0][31:0] ch1;
    logic [3:0][31:0]  e0;
    logic [3:0][31:0]  e1;
  } vec_t;

  vec_t tbl [2];
  logic [31:0] P16 [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                            32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                            32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

  int errors = 0;
  int checks = 0;
  int n_valid_s, n_last_s, n_valid_b, n_last_b;
  logic [63:0] held_s;

  logic [BCH*DW-1:0] frame [BPIX];
  logic [BCH*DW-1:0] exp_q [BOUT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ordering: map each pattern to an unsigned key where a larger key wins.
  function automatic logic [32:0] order_key(input logic [31:0] x);
    return x[31] ? {1'b0, ~x} : {1'b1, x};
  endfunction

  function automatic logic [BCH*DW-1:0] ref_max(input logic [BCH*DW-1:0] a,
                                                input logic [BCH*DW-1:0] b);
    logic [BCH*DW-1:0] r;
    for (int k = 0; k < BCH; k++)
      r[k*32 +: 32] = (order_key(b[k*32 +: 32]) > order_key(a[k*32 +: 32])) ?
                      b[k*32 +: 32] : a[k*32 +: 32];
    return r;
  endfunction

  task automatic step_s(input logic v, input logic [63:0] d, input logic ev,
                        input logic el, input logic [63:0] ed, input string tag);
    sif.valid_in = v;
    sif.data_in  = d;
    @(negedge clk);
    chk({tag, ".valid"}, 64'(sif.valid_out), 64'(ev));
    chk({tag, ".last"}, 64'(sif.last_out), 64'(el));
    chk({tag, ".data"}, sif.data_out, ed);
    if (sif.valid_out) n_valid_s++;
    if (sif.last_out) n_last_s++;
  endtask

  task automatic run_frame(input int t, input int max_gap, input int n_beats,
                           input bit end_idle, input string tag);
    for (int idx = 0; idx < n_beats; idx++) begin
      int r, c, k, gap;
      logic ev;
      r  = idx / 4;
      c  = idx % 4;
      ev = (r % 2 == 1) && (c % 2 == 1);
      k  = (r / 2) * 2 + c / 2;
      if (ev) held_s = {tbl[t].e1[k], tbl[t].e0[k]};
      step_s(1'b1, {tbl[t].ch1[idx], tbl[t].ch0[idx]}, ev, idx == 15, held_s,
             $sformatf("%s[%0d]", tag, idx));
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int g = 0; g < gap; g++)
        step_s(1'b0, {$urandom, $urandom}, 1'b0, 1'b0, held_s,
               $sformatf("%s[%0d]idle", tag, idx));
    end
    if (end_idle) sif.valid_in = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sif.valid_in = 1'b0; sif.data_in = '0;
    bif.valid_in = 1'b0; bif.data_in = '0;

    tbl[0].name = "basic";
    for (int i = 0; i < 16; i++) begin
      tbl[0].ch0[i] = P16[i];
      tbl[0].ch1[i] = P16[i] | 32'h80000000;
    end
    tbl[0].e0[0] = 32'h40C00000; tbl[0].e0[1] = 32'h41000000;
    tbl[0].e0[2] = 32'h41600000; tbl[0].e0[3] = 32'h41800000;
    tbl[0].e1[0] = 32'hBF800000; tbl[0].e1[1] = 32'hC0400000;
    tbl[0].e1[2] = 32'hC1100000; tbl[0].e1[3] = 32'hC1300000;

    tbl[1].name = "sign";
    tbl[1].ch0[0]  = 32'hBF000000; tbl[1].ch0[1]  = 32'hC0000000;
    tbl[1].ch0[4]  = 32'hBE800000; tbl[1].ch0[5]  = 32'hC1000000;
    tbl[1].ch0[2]  = 32'h00000000; tbl[1].ch0[3]  = 32'h80000000;
    tbl[1].ch0[6]  = 32'hBF800000; tbl[1].ch0[7]  = 32'hC0400000;
    tbl[1].ch0[8]  = 32'h80000000; tbl[1].ch0[9]  = 32'h80000000;
    tbl[1].ch0[12] = 32'h80000000; tbl[1].ch0[13] = 32'h80000000;
    tbl[1].ch0[10] = 32'h7F800000; tbl[1].ch0[11] = 32'h7FC00000;
    tbl[1].ch0[14] = 32'h3F800000; tbl[1].ch0[15] = 32'hFF800000;
    for (int i = 0; i < 16; i++) tbl[1].ch1[i] = 32'h3F800000;
    tbl[1].e0[0] = 32'hBE800000; tbl[1].e0[1] = 32'h00000000;
    tbl[1].e0[2] = 32'h80000000; tbl[1].e0[3] = 32'h7FC00000;
    for (int i = 0; i < 4; i++) tbl[1].e1[i] = 32'h3F800000;

    // Reset state
    @(negedge clk);
    chk("rst.small.valid", 64'(sif.valid_out), 64'd0);
    chk("rst.small.last", 64'(sif.last_out), 64'd0);
    chk("rst.small.data", sif.data_out, 64'd0);
    chk("rst.big.valid", 64'(bif.valid_out), 64'd0);
    chk("rst.big.data", bif.data_out[63:0], 64'd0);
    rst_n = 1'b1;
    held_s = '0;

    for (int t = 0; t < 2; t++) begin
      n_valid_s = 0; n_last_s = 0;
      run_frame(t, 0, 16, 1'b1, tbl[t].name);
      step_s(1'b0, '0, 1'b0, 1'b0, held_s, {tbl[t].name, ".tail"});
      chk({tbl[t].name, ".nvalid"}, 64'(n_valid_s), 64'd4);
      chk({tbl[t].name, ".nlast"}, 64'(n_last_s), 64'd1);
    end

    n_valid_s = 0; n_last_s = 0;
    run_frame(0, 5, 16, 1'b1, "gapped");
    step_s(1'b0, '0, 1'b0, 1'b0, held_s, "gapped.tail");
    chk("gapped.nvalid", 64'(n_valid_s), 64'd4);

    n_valid_s = 0; n_last_s = 0;
    run_frame(0, 0, 16, 1'b0, "b2b_f1");
    run_frame(0, 0, 16, 1'b1, "b2b_f2");
    step_s(1'b0, '0, 1'b0, 1'b0, held_s, "b2b.tail");
    chk("b2b.nvalid", 64'(n_valid_s), 64'd8);
    chk("b2b.nlast", 64'(n_last_s), 64'd2);

    // Reset after 9 beats: outputs must clear without waiting for a clock edge
    run_frame(0, 0, 9, 1'b1, "prerst");
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.valid", 64'(sif.valid_out), 64'd0);
    chk("midrst.last", 64'(sif.last_out), 64'd0);
    chk("midrst.data", sif.data_out, 64'd0);
    held_s = '0;
    @(negedge clk);
    rst_n = 1'b1;
    n_valid_s = 0; n_last_s = 0;
    run_frame(0, 0, 16, 1'b1, "postrst");
    step_s(1'b0, '0, 1'b0, 1'b0, held_s, "postrst.tail");
    chk("postrst.nvalid", 64'(n_valid_s), 64'd4);
    chk("postrst.nlast", 64'(n_last_s), 64'd1);

    // Full-size random frame
    for (int p = 0; p < BPIX; p++)
      for (int ch = 0; ch < BCH; ch++) begin
        logic [31:0] x;
        int sel;
        x = $urandom;
        sel = $urandom_range(7, 0);
        if (sel == 0) x = 32'h00000000;
        else if (sel == 1) x = 32'h80000000;
        frame[p][ch*32 +: 32] = x;
      end
    for (int r = 0; r < BN / 2; r++)
      for (int c = 0; c < BN / 2; c++) begin
        int b0, b1;
        b0 = (2 * r) * BN + 2 * c;
        b1 = b0 + BN;
        exp_q[r * (BN / 2) + c] = ref_max(ref_max(frame[b0], frame[b0 + 1]),
                                          ref_max(frame[b1], frame[b1 + 1]));
      end

    n_valid_b = 0; n_last_b = 0;
    begin
      int k;
      k = 0;
      for (int p = 0; p < BPIX; p++) begin
        logic ev;
        bif.valid_in = 1'b1;
        bif.data_in  = frame[p];
        @(negedge clk);
        ev = ((p / BN) % 2 == 1) && ((p % BN) % 2 == 1);
        chk($sformatf("big[%0d].valid", p), 64'(bif.valid_out), 64'(ev));
        chk($sformatf("big[%0d].last", p), 64'(bif.last_out), 64'(p == BPIX - 1));
        if (bif.valid_out) n_valid_b++;
        if (bif.last_out) n_last_b++;
        if (ev && k < BOUT) begin
          int bad;
          bad = -1;
          for (int ch = BCH - 1; ch >= 0; ch--)
            if (bif.data_out[ch*32 +: 32] !== exp_q[k][ch*32 +: 32]) bad = ch;
          if (bad < 0) chk($sformatf("big_out[%0d]", k), 64'(bif.data_out[31:0]),
                           64'(exp_q[k][31:0]));
          else chk($sformatf("big_out[%0d].ch%0d", k, bad),
                   64'(bif.data_out[bad*32 +: 32]), 64'(exp_q[k][bad*32 +: 32]));
          k++;
        end
      end
      bif.valid_in = 1'b0;
      @(negedge clk);
      chk("big.tail.valid", 64'(bif.valid_out), 64'd0);
      chk("big.nvalid", 64'(n_valid_b), 64'(BOUT));
      chk("big.nlast", 64'(n_last_b), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
